// File: rtl/log_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : log_capture_ctrl
// Purpose  : Sequences the single-port log BRAM behind the DSP chain.
//            Arbitrates the RAM between decimated, optionally triggered
//            sample capture and micro read-back through the register file.
// Revision : 1.0 - initial release
// ============================================================================
module log_capture_ctrl #(
   parameter int NB_DATA  = 32,
   parameter int NB_ADDR  = 15,
   parameter int NB_DECIM = 4
) (
   input  logic                clock,
   input  logic                in_reset,
   input  logic                i_run,
   input  logic                i_trig_en,
   input  logic                i_trigger,
   input  logic                i_valid,
   input  logic [NB_DECIM-1:0] i_decim,
   input  logic [NB_DATA-1:0]  i_data,
   input  logic [NB_ADDR-1:0]  i_read_addr,
   output logic                o_ram_we,
   output logic [NB_ADDR-1:0]  o_ram_addr,
   output logic [NB_DATA-1:0]  o_ram_wdata,
   input  logic [NB_DATA-1:0]  i_ram_rdata,
   output logic [NB_DATA-1:0]  o_read_data,
   output logic                o_full,
   output logic                o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_FULL    = 2'd3
   } state_t;

   localparam logic [NB_ADDR-1:0]  LAST_ADDR = '1;
   localparam logic [NB_ADDR-1:0]  PTR_ONE   = 1;
   localparam logic [NB_DECIM-1:0] DCNT_ONE  = 1;

   state_t               state, state_nx;
   logic                 run_d;
   logic [NB_ADDR-1:0]   ptr, ptr_nx;
   logic [NB_DECIM-1:0]  dcnt, dcnt_nx;
   logic                 we_nx;
   logic [NB_ADDR-1:0]   addr_nx;
   logic [NB_DATA-1:0]   wdata_nx;
   logic                 full_nx;
   logic                 busy_nx;
   logic                 do_write;
   logic                 rd_ok;
   logic                 rd_ok_d;

   // The RAM is free for read-back only in IDLE/FULL; the output register
   // updates only after a full cycle there so the RAM has seen the read address.
   assign rd_ok = (state == ST_IDLE) || (state == ST_FULL);

   // Next-state and next-output decode; a low i_run overrides everything.
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      dcnt_nx  = dcnt;
      we_nx    = 1'b0;
      addr_nx  = o_ram_addr;
      wdata_nx = o_ram_wdata;
      full_nx  = o_full;
      do_write = 1'b0;
      if (!i_run) begin
         state_nx = ST_IDLE;
         full_nx  = 1'b0;
         addr_nx  = i_read_addr;
      end else begin
         case (state)
            ST_IDLE: begin
               addr_nx = i_read_addr;
               if (!run_d) begin
                  ptr_nx   = '0;
                  dcnt_nx  = '0;
                  state_nx = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (!i_trig_en) begin
                  state_nx = ST_CAPTURE;
               end else if (i_trigger && i_valid) begin
                  // The trigger sample itself is the first one logged.
                  do_write = 1'b1;
                  state_nx = ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (i_valid) begin
                  if (dcnt == '0) begin
                     do_write = 1'b1;
                  end else begin
                     dcnt_nx = dcnt - DCNT_ONE;
                  end
               end
            end
            default: begin
               addr_nx = i_read_addr;
            end
         endcase
      end
      if (do_write) begin
         we_nx    = 1'b1;
         addr_nx  = ptr;
         wdata_nx = i_data;
         dcnt_nx  = i_decim;
         if (ptr == LAST_ADDR) begin
            // Last word: stop here instead of wrapping the pointer.
            state_nx = ST_FULL;
            full_nx  = 1'b1;
         end else begin
            ptr_nx = ptr + PTR_ONE;
         end
      end
      busy_nx = (state_nx == ST_ARMED) || (state_nx == ST_CAPTURE);
   end

   // State, pointers and all registered outputs.
   always_ff @(posedge clock or negedge in_reset) begin
      if (!in_reset) begin
         state       <= ST_IDLE;
         run_d       <= 1'b0;
         ptr         <= '0;
         dcnt        <= '0;
         rd_ok_d     <= 1'b0;
         o_ram_we    <= 1'b0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
         o_read_data <= '0;
         o_full      <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         state       <= state_nx;
         run_d       <= i_run;
         ptr         <= ptr_nx;
         dcnt        <= dcnt_nx;
         rd_ok_d     <= rd_ok;
         o_ram_we    <= we_nx;
         o_ram_addr  <= addr_nx;
         o_ram_wdata <= wdata_nx;
         o_full      <= full_nx;
         o_busy      <= busy_nx;
         if (rd_ok && rd_ok_d) begin
            o_read_data <= i_ram_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_log_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_capture_ctrl
// Purpose  : Self-checking bench for log_capture_ctrl (16-word RAM).
//            Expected writes are queued as stimulus is driven and popped by
//            a write monitor; a behavioural sync RAM closes the read path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_log_capture_ctrl;

   localparam int NB_DATA  = 32;
   localparam int NB_ADDR  = 4;
   localparam int NB_DECIM = 4;

   logic                clock = 1'b0;
   logic                in_reset;
   logic                i_run, i_trig_en, i_trigger, i_valid;
   logic [NB_DECIM-1:0] i_decim;
   logic [NB_DATA-1:0]  i_data;
   logic [NB_ADDR-1:0]  i_read_addr;
   logic                o_ram_we;
   logic [NB_ADDR-1:0]  o_ram_addr;
   logic [NB_DATA-1:0]  o_ram_wdata;
   logic [NB_DATA-1:0]  i_ram_rdata;
   logic [NB_DATA-1:0]  o_read_data;
   logic                o_full, o_busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NB_ADDR-1:0] addr;
      logic [NB_DATA-1:0] data;
      logic               full;
   } exp_t;
   exp_t sb[$];

   logic [NB_DATA-1:0] mem [0:(1<<NB_ADDR)-1];

   log_capture_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_DECIM(NB_DECIM)) dut (
      .clock(clock), .in_reset(in_reset), .i_run(i_run), .i_trig_en(i_trig_en),
      .i_trigger(i_trigger), .i_valid(i_valid), .i_decim(i_decim), .i_data(i_data),
      .i_read_addr(i_read_addr), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
      .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata), .o_read_data(o_read_data),
      .o_full(o_full), .o_busy(o_busy)
   );

   always #5 clock = ~clock;

   // Single-port synchronous RAM, read-before-write.
   always @(posedge clock) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      i_ram_rdata <= mem[o_ram_addr];
   end

   task automatic check(input string tag, input logic [NB_DATA-1:0] obs,
                        input logic [NB_DATA-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int addr, input int data, input logic full);
      exp_t e;
      e.addr = addr[NB_ADDR-1:0];
      e.data = data;
      e.full = full;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we"},    {31'd0, o_ram_we},   0);
      check({tag, "_addr"},  {28'd0, o_ram_addr}, 0);
      check({tag, "_wdata"}, o_ram_wdata,         0);
      check({tag, "_rdata"}, o_read_data,         0);
      check({tag, "_full"},  {31'd0, o_full},     0);
      check({tag, "_busy"},  {31'd0, o_busy},     0);
   endtask

   // Every RAM write must match the oldest queued expectation.
   always @(negedge clock) begin
      if (in_reset && o_ram_we) begin
         check("write_expected", {31'd0, sb.size() != 0}, 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("write_addr", {28'd0, o_ram_addr}, {28'd0, e.addr});
            check("write_data", o_ram_wdata, e.data);
            check("write_full", {31'd0, o_full}, {31'd0, e.full});
            check("write_busy", {31'd0, o_busy}, {31'd0, ~e.full});
         end
      end
   end

   initial begin
      in_reset = 1'b0; i_run = 1'b0; i_trig_en = 1'b0; i_trigger = 1'b0;
      i_valid = 1'b0; i_decim = '0; i_data = '0; i_read_addr = '0;
      for (int i = 0; i < (1 << NB_ADDR); i++) mem[i] = 32'hdead0000 + i;
      repeat (3) step();
      check_all_zero("reset");
      in_reset = 1'b1;
      step();

      // Basic fill: continuous valid after arming, ramp data.
      i_run = 1'b1;
      step(); step();
      for (int k = 0; k < 20; k++) begin
         if (k < 16) push(k, k, k == 15);
         i_valid = 1'b1; i_data = k;
         step();
      end
      i_valid = 1'b0;
      check("fill_full", {31'd0, o_full}, 1);
      check("fill_busy", {31'd0, o_busy}, 0);
      check("fill_no_we", {31'd0, o_ram_we}, 0);
      check("fill_drain", sb.size(), 0);
      i_run = 1'b0;
      step();
      check("stop_clears_full", {31'd0, o_full}, 0);

      // Read-back latency.
      i_read_addr = 4'd3;
      repeat (5) step();
      check("read_addr3", o_read_data, 3);
      i_read_addr = 4'd7;
      step(); step();
      check("read_not_early", o_read_data, 3);
      step();
      check("read_addr7", o_read_data, 7);

      // Decimation by 3; read data must hold during capture.
      i_decim = 4'd2; i_run = 1'b1;
      step(); step();
      for (int n = 0; n < 49; n++) begin
         if (n < 46 && n % 3 == 0) push(n / 3, n, n == 45);
         i_valid = 1'b1; i_data = n;
         if (n == 20) i_read_addr = 4'd9;
         step();
         if (n == 30) check("read_hold", o_read_data, 7);
      end
      i_valid = 1'b0;
      check("decim_full", {31'd0, o_full}, 1);
      check("decim_drain", sb.size(), 0);
      i_run = 1'b0; i_decim = '0;
      step();

      // Trigger at sample 100; an invalid-cycle trigger earlier is ignored.
      i_trig_en = 1'b1; i_run = 1'b1;
      step();
      for (int k = 0; k < 120; k++) begin
         if (k == 50) begin
            i_valid = 1'b0; i_trigger = 1'b1;
            step();
         end
         i_valid = 1'b1; i_data = k; i_trigger = (k == 100);
         if (k >= 100 && k <= 115) push(k - 100, k, k == 115);
         step();
      end
      i_valid = 1'b0; i_trigger = 1'b0;
      check("trig_full", {31'd0, o_full}, 1);
      check("trig_drain", sb.size(), 0);
      i_run = 1'b0; i_trig_en = 1'b0;
      step();

      // Abort after 5 writes.
      i_run = 1'b1;
      step(); step();
      for (int k = 0; k < 5; k++) begin
         push(k, 200 + k, 1'b0);
         i_valid = 1'b1; i_data = 200 + k;
         step();
      end
      i_run = 1'b0; i_valid = 1'b0;
      step();
      check("abort_we", {31'd0, o_ram_we}, 0);
      check("abort_full", {31'd0, o_full}, 0);
      check("abort_busy", {31'd0, o_busy}, 0);

      // Restart from address 0; abort coincides with the final write.
      i_run = 1'b1;
      step(); step();
      for (int k = 0; k < 16; k++) begin
         i_valid = 1'b1; i_data = 300 + k;
         if (k < 15) push(k, 300 + k, 1'b0);
         else i_run = 1'b0;
         step();
      end
      i_valid = 1'b0;
      step();
      check("abort_last_full", {31'd0, o_full}, 0);
      check("abort_last_busy", {31'd0, o_busy}, 0);
      check("abort_last_drain", sb.size(), 0);

      // Asynchronous reset mid-capture.
      i_run = 1'b1;
      step(); step();
      for (int k = 0; k < 3; k++) begin
         push(k, 400 + k, 1'b0);
         i_valid = 1'b1; i_data = 400 + k;
         step();
      end
      @(negedge clock);
      #2;
      in_reset = 1'b0; i_valid = 1'b0; i_run = 1'b0;
      #1;
      check_all_zero("async_reset");
      step();
      in_reset = 1'b1;
      step(); step();
      check("post_reset_busy", {31'd0, o_busy}, 0);
      i_run = 1'b1;
      step(); step();
      push(0, 500, 1'b0);
      i_valid = 1'b1; i_data = 500;
      step();
      i_valid = 1'b0;
      step();
      i_run = 1'b0;
      step(); step();
      check("final_drain", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/log_capture_ctrl.md
Name: log_capture_ctrl

Overview:
- Sequences the single-port log BRAM that sits behind the DSP chain.
- Arbitrates the RAM between two requesters:
  - capture writes of equalizer samples at symbol rate;
  - micro read-back through the register file (run / full / read-address handshake).
- Supports decimated capture and an optional start trigger.
- Sits between dsp and register_file, in the clockdsp domain.

Parameters:
- NB_DATA, 32, width of a logged word (RAM data width).
- NB_ADDR, 15, RAM address width; depth = 2**NB_ADDR.
- NB_DECIM, 4, width of the decimation factor.

Ports:
- clock  in  1  DSP clock (clockdsp).
- in_reset  in  1  asynchronous, active-low reset.
- i_run  in  1  level from micro; 1 = arm/capture, 0 = stop/clear.
- i_trig_en  in  1  1 = wait for i_trigger before capturing.
- i_trigger  in  1  single-cycle capture trigger (sampled only while i_valid=1).
- i_valid  in  1  sample strobe (enable from rf_enables_module).
- i_decim  in  NB_DECIM  store 1 of every i_decim+1 valid samples.
- i_data  in  NB_DATA  sample to log.
- i_read_addr  in  NB_ADDR  micro read address.
- o_ram_we  out  1  RAM write enable.
- o_ram_addr  out  NB_ADDR  RAM address.
- o_ram_wdata  out  NB_DATA  RAM write data.
- i_ram_rdata  in  NB_DATA  RAM read data (synchronous RAM, 1-cycle read).
- o_read_data  out  NB_DATA  read-back data to register file.
- o_full  out  1  memory full / capture complete.
- o_busy  out  1  FSM in ARMED or CAPTURE.

Behaviour:
- All outputs are registered.
- Reset (in_reset=0, asynchronous):
  - state=IDLE;
  - o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, o_read_data=0, o_full=0, o_busy=0;
  - write pointer=0, decimation counter=0, run_d=0.
- run_d is i_run delayed one cycle. Run rise = i_run & ~run_d.
- States:
  - IDLE:
    - o_ram_addr <= i_read_addr; o_ram_we=0.
    - On run rise: write pointer <= 0, decimation counter <= 0, go to ARMED.
  - ARMED:
    - If i_trig_en=0, go to CAPTURE next cycle.
    - Otherwise wait for i_trigger=1 with i_valid=1. That sample is the first sample captured: it is written in the same transition.
  - CAPTURE, on each i_valid:
    - If decimation counter==0: o_ram_we<=1, o_ram_addr<=pointer, o_ram_wdata<=i_data, pointer++, counter<=i_decim.
    - Else: counter--, o_ram_we<=0.
    - No i_valid: o_ram_we<=0.
    - When the write at pointer==2**NB_ADDR-1 issues: go to FULL, o_full<=1 in that same edge.
  - FULL:
    - o_ram_we=0; o_ram_addr <= i_read_addr.
    - o_full stays 1 while i_run=1.
- i_run=0 in any state: next state IDLE, o_full<=0, o_ram_we<=0. This aborts a capture mid-operation; RAM contents are retained.
- A run rise while in FULL is impossible; i_run must first drop, which clears o_full.
- Read path:
  - o_read_data <= i_ram_rdata whenever state is IDLE or FULL, and it was IDLE/FULL in the previous cycle too.
  - Otherwise o_read_data holds its value.
  - Read latency = 3 clocks from i_read_addr change to o_read_data: address register, RAM, output register.
- Decimation:
  - i_decim is sampled on every reload.
  - i_decim=0 stores every valid sample.
  - Maximum i_decim = 2**NB_DECIM-1.
- o_busy = (state==ARMED) | (state==CAPTURE), registered.
- Simultaneous events:
  - i_run falling with the final write: abort wins; o_full stays 0.
  - i_trigger with i_valid=0 is ignored.
- Pointer never wraps: capture stops at the last address.

Test Plan:
- All tests use NB_ADDR=4 (16 words).
- Reset: in_reset=0 mid-CAPTURE -> all outputs 0 immediately (asynchronous); state IDLE after release.
- Basic fill: i_trig_en=0, i_decim=0, i_valid=1 continuous, i_data=pointer-valued ramp 0..15, i_run 0->1 -> sequence is:
  - 16 writes, addresses 0..15, data 0..15;
  - o_full=1 on the same edge as the write to address 15;
  - o_busy 1->0 at that edge;
  - no further writes.
- Decimation: i_decim=2, i_data=n on the n-th valid -> stored words are 0,3,6,...,45; o_full after the 46th valid sample.
- Trigger: i_trig_en=1, ramp data, i_trigger pulsed with i_valid at sample 100 -> address 0 holds 100, address 15 holds 115; no writes before the trigger.
- Abort: i_run drops after 5 writes -> next cycle IDLE, o_ram_we=0, o_full=0. Re-raising i_run restarts at address 0.
- Read-back: after fill, i_read_addr=7 -> o_read_data=7 exactly 3 clocks later. During CAPTURE, o_read_data holds its last value regardless of i_read_addr.
